// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter.
//   ramstate_t  : handshake state reported by the single-ported RAM
//   arb_state_t : arbiter grant state
//   word_t      : native machine word
package cpu_types_pkg;

  localparam int WORD_W   = 32;
  localparam int STARVE_W = 4;   // starve counter width, supports STARVE_MAX up to 15

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates the instruction-side and data-side cache requests onto one
// single-ported RAM. Data wins ties; after STARVE_MAX back-to-back data
// completions with an instruction fetch waiting, one instruction grant is
// forced so fetch always makes progress.
//
// Ports:
//   CLK, nRST                      clock (rising edge), async active-high reset
//   iREN, iaddr / iload, iwait     instruction read request and response
//   dREN, dWEN, daddr, dstore      data read/write request
//   dload, dwait                   data response
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   RAM command and response
//
// A grant lasts until the RAM reports ACCESS (completion, wait drops for one
// cycle) or the granted requester drops its request (abort, no wait pulse).
// Every grant returns through IDLE, giving one bubble between accesses.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  ramstate_t ram_st;
  logic      d_req;
  logic      starve_full;
  logic      d_done;
  logic      i_done;

  assign ram_st      = ramstate_t'(ramstate);
  assign d_req       = dREN | dWEN;
  assign starve_full = (starve_q == STARVE_W'(STARVE_MAX));
  // Completion needs the request still present; a dropped request is an abort.
  assign d_done      = (state_q == DGRANT) && d_req && (ram_st == ACCESS);
  assign i_done      = (state_q == IGRANT) && iREN  && (ram_st == ACCESS);

  // State register and starve counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(iREN && starve_full)) state_d = DGRANT;
        else if (iREN)                       state_d = IGRANT;
      end
      DGRANT:  if (!d_req || d_done) state_d = IDLE;
      IGRANT:  if (!iREN  || i_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starve counter: counts data completions that overtook a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (!iREN || i_done)           starve_d = '0;
    else if (d_done && !starve_full) starve_d = starve_q + STARVE_W'(1);
  end

  // Outputs. RAM command follows the granted requester combinationally, so
  // dropping the request removes the enables in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !d_done;
        // Writes return no data.
        if (d_done && dREN) dload = ramload;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !i_done;
        if (i_done) iload = ramload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios with literal
// expectations plus a transaction-level reference model compared against
// every DUT output on every negative clock edge.
module tb_memory_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN;
  logic [AW-1:0] iaddr, daddr, ramaddr;
  logic [DW-1:0] iload, dload, dstore, ramstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN;
  logic [1:0]    ramstate;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: who currently holds the RAM (0 = nobody, 1 = data, 2 = instruction)
  // streak: data completions that have jumped ahead of a waiting fetch
  int          m_owner  = 0;
  int          m_streak = 0;
  logic [63:0] m_seq    = '0;  // completions, one nibble each: D = data, 1 = instr
  bit          cmp_en   = 1'b0;
  bit          mb_dreq, mb_ddone, mb_idone;

  always @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      m_owner  = 0;
      m_streak = 0;
    end else begin
      mb_dreq  = dREN || dWEN;
      mb_ddone = (m_owner == 1) && mb_dreq && (ramstate == RS_ACCESS);
      mb_idone = (m_owner == 2) && iREN && (ramstate == RS_ACCESS);
      if (mb_ddone) m_seq = (m_seq << 4) | 64'hD;
      if (mb_idone) m_seq = (m_seq << 4) | 64'h1;
      if (m_owner == 0) begin
        if (mb_dreq && !(iREN && m_streak >= SMAX)) m_owner = 1;
        else if (iREN)                              m_owner = 2;
      end else if (m_owner == 1) begin
        if (!mb_dreq || mb_ddone) m_owner = 0;
      end else begin
        if (!iREN || mb_idone) m_owner = 0;
      end
      if (!iREN || mb_idone) m_streak = 0;
      else if (mb_ddone)     m_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
    end
  end

  logic          e_ren, e_wen, e_iwait, e_dwait;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_store, e_iload, e_dload;

  always @(negedge CLK) begin
    if (cmp_en) begin
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      e_iwait = 1'b1; e_dwait = 1'b1; e_iload = '0; e_dload = '0;
      if (!nRST && m_owner == 1) begin
        e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
        if ((dREN || dWEN) && ramstate == RS_ACCESS) begin
          e_dwait = 1'b0;
          e_dload = dREN ? ramload : '0;
        end
      end else if (!nRST && m_owner == 2) begin
        e_ren = iREN; e_addr = iaddr;
        if (iREN && ramstate == RS_ACCESS) begin
          e_iwait = 1'b0;
          e_iload = ramload;
        end
      end
      check("cmp_ramREN",   ramREN,   e_ren);
      check("cmp_ramWEN",   ramWEN,   e_wen);
      check("cmp_ramaddr",  ramaddr,  e_addr);
      check("cmp_ramstore", ramstore, e_store);
      check("cmp_iwait",    iwait,    e_iwait);
      check("cmp_dwait",    dwait,    e_dwait);
      check("cmp_iload",    iload,    e_iload);
      check("cmp_dload",    dload,    e_dload);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  logic [63:0] dut_seq;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
    cmp_en = 1'b1;
    cyc(); cyc();
    @(negedge CLK);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramWEN", ramWEN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    cyc(); nRST = 1'b0;
    cyc();

    // Instruction read, BUSY twice then ACCESS.
    iREN = 1'b1; iaddr = 32'h100; ramstate = RS_BUSY; ramload = 32'hDEADBEEF;
    @(negedge CLK); check("ifetch_idle_ren", ramREN, 0);
    cyc(); @(negedge CLK);
    check("ifetch_ren", ramREN, 1);
    check("ifetch_addr", ramaddr, 64'h100);
    check("ifetch_busy_iwait", iwait, 1);
    cyc(); @(negedge CLK); check("ifetch_busy2_iwait", iwait, 1);
    cyc(); ramstate = RS_ACCESS; @(negedge CLK);
    check("ifetch_iwait", iwait, 0);
    check("ifetch_iload", iload, 64'hDEADBEEF);
    check("ifetch_dwait", dwait, 1);
    cyc(); ramstate = RS_FREE; @(negedge CLK);
    check("ifetch_bubble_ren", ramREN, 0);
    cyc(); iREN = 1'b0;
    cyc(); cyc();

    // Collision: data write beats instruction fetch.
    iREN = 1'b1; iaddr = 32'h104; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
    ramstate = RS_BUSY; ramload = 32'hCAFEF00D;
    cyc(); @(negedge CLK);
    check("coll_wen", ramWEN, 1);
    check("coll_store", ramstore, 64'h12345678);
    check("coll_addr", ramaddr, 64'h200);
    cyc(); ramstate = RS_ACCESS; @(negedge CLK);
    check("coll_dwait", dwait, 0);
    check("coll_dload_gated", dload, 0);
    check("coll_iwait", iwait, 1);
    cyc(); dWEN = 1'b0; @(negedge CLK);
    check("coll_bubble_ren", ramREN, 0);
    check("coll_bubble_wen", ramWEN, 0);
    cyc(); @(negedge CLK);
    check("coll_iaddr", ramaddr, 64'h104);
    check("coll_iwait_done", iwait, 0);
    check("coll_iload", iload, 64'hCAFEF00D);
    cyc(); iREN = 1'b0;
    cyc(); cyc();

    // Starvation: continuous data reads with a fetch pending.
    iREN = 1'b1; iaddr = 32'h180; dREN = 1'b1; daddr = 32'h300;
    ramstate = RS_ACCESS; ramload = 32'hA5A5A5A5;
    m_seq = '0; dut_seq = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (dwait === 1'b0) dut_seq = (dut_seq << 4) | 64'hD;
      if (iwait === 1'b0) dut_seq = (dut_seq << 4) | 64'h1;
      cyc();
    end
    dREN = 1'b0; iREN = 1'b0;
    check("starve_seq_dut", dut_seq, 64'hDDDD1DD);
    check("starve_seq_model", m_seq, 64'hDDDD1DD);
    cyc(); cyc();

    // Error retry: three ERROR cycles then ACCESS.
    dREN = 1'b1; daddr = 32'h400; ramstate = RS_ERROR; ramload = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge CLK);
      check("err_ren", ramREN, 1);
      check("err_dwait", dwait, 1);
    end
    cyc(); ramstate = RS_ACCESS; @(negedge CLK);
    check("err_dwait_done", dwait, 0);
    check("err_dload", dload, 64'h55AA55AA);
    cyc(); dREN = 1'b0; ramstate = RS_FREE;
    cyc(); cyc();

    // Abort: data read dropped while RAM is BUSY.
    dREN = 1'b1; daddr = 32'h500; ramstate = RS_BUSY; ramload = 32'h0BADF00D;
    cyc(); @(negedge CLK); check("abort_ren", ramREN, 1);
    cyc(); dREN = 1'b0; @(negedge CLK);
    check("abort_ren_drop", ramREN, 0);
    check("abort_dwait", dwait, 1);
    cyc(); dREN = 1'b1; ramstate = RS_ACCESS; @(negedge CLK);
    check("abort_idle_ren", ramREN, 0);
    check("abort_idle_dwait", dwait, 1);
    cyc(); @(negedge CLK);
    check("abort_regrant_dwait", dwait, 0);
    check("abort_regrant_dload", dload, 64'h0BADF00D);
    cyc(); dREN = 1'b0; ramstate = RS_FREE;
    cyc(); cyc();

    // Reset in the middle of a BUSY data grant.
    dREN = 1'b1; daddr = 32'h600; ramstate = RS_BUSY; ramload = 32'h13579BDF;
    cyc(); @(negedge CLK); check("mrst_pre_ren", ramREN, 1);
    cyc(); nRST = 1'b1; #1;
    check("mrst_async_ren", ramREN, 0);
    check("mrst_async_dwait", dwait, 1);
    @(negedge CLK);
    check("mrst_ren", ramREN, 0);
    check("mrst_dload", dload, 0);
    cyc(); nRST = 1'b0; ramstate = RS_ACCESS; @(negedge CLK);
    check("mrst_idle_ren", ramREN, 0);
    check("mrst_idle_dwait", dwait, 1);
    cyc(); @(negedge CLK);
    check("mrst_recover_dwait", dwait, 0);
    check("mrst_recover_dload", dload, 64'h13579BDF);
    cyc(); dREN = 1'b0; ramstate = RS_FREE;
    cyc(); cyc();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
